// File: rtl/dmem_bank_pkg.sv
// Shared definitions for the data-memory bank: controller states and
// default geometry.
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 150000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DUMP  = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_bank_store.sv
// Single-port synchronous RAM with byte-lane write enables and read-first
// behaviour. Each byte lane is its own narrow array, so a lane write never
// touches the other lanes. No reset: contents and output register power up
// undefined.
module dmem_bank_store #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     q
);

  localparam int NB = DATA_W / 8;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;

      // Read-first lane access: the output register captures the old byte
      // even when the same lane is written in this cycle.
      always_ff @(posedge clk) begin
        if (en) begin
          lane_q_reg <= lane_mem[addr];
          if (we && be[gi]) begin
            lane_mem[addr] <= wd[gi*8 +: 8];
          end
        end
      end

      assign q[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate

endmodule

// File: rtl/dmem_bank.sv
// Data-memory bank: byte-writable word RAM with a controller that serves
// single reads/writes in IDLE, zeroes the whole array in CLEAR, and streams
// every word out over a valid/ready port in DUMP. DEPTH must be at least 2.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd,
  output logic                  rvalid,
  output logic                  err,
  input  logic                  clr_start,
  input  logic                  dump_start,
  output logic [DATA_W-1:0]     dump_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic                  dump_last,
  output logic                  busy
);

  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);

  dmem_state_t       state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              dump_valid_reg, dump_valid_next;
  logic              rvalid_reg, rd_oor_reg, err_reg;
  logic [DATA_W-1:0] rd_hold_reg;

  logic              in_range;
  logic              ram_en, ram_we;
  logic [NB-1:0]     ram_be;
  logic [CW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wd, ram_q;

  // Compare one bit wider so DEPTH == 2**ADDR_W does not wrap to zero.
  assign in_range = {1'b0, address} < (ADDR_W + 1)'(DEPTH);

  dmem_bank_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (CW)
  ) u_store (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (ram_be),
    .addr (ram_addr),
    .wd   (ram_wd),
    .q    (ram_q)
  );

  // Next-state, counter and RAM port steering for the three modes.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    dump_valid_next = dump_valid_reg;
    ram_en          = 1'b0;
    ram_we          = 1'b0;
    ram_be          = '0;
    ram_addr        = cnt_reg;
    ram_wd          = '0;
    case (state_reg)
      ST_IDLE: begin
        ram_addr = address[CW-1:0];
        ram_wd   = wd;
        ram_be   = be;
        ram_we   = we && in_range;
        ram_en   = (we || re) && in_range;
        cnt_next = '0;
        if (clr_start) begin
          state_next = ST_CLEAR;
        end else if (dump_start) begin
          state_next = ST_DUMP;
        end
      end
      ST_CLEAR: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        ram_be = '1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_DUMP: begin
        if (!dump_valid_reg) begin
          // First DUMP cycle: fetch word 0 so it is presented next cycle.
          ram_en          = 1'b1;
          dump_valid_next = 1'b1;
        end else if (dump_ready) begin
          if (cnt_reg == LAST_ADDR) begin
            state_next      = ST_IDLE;
            cnt_next        = '0;
            dump_valid_next = 1'b0;
          end else begin
            // Fetch the following word during the transfer so a held-high
            // ready sees one word per cycle; without ready the RAM output
            // register is left alone and keeps dump_data stable.
            cnt_next = cnt_reg + CW'(1);
            ram_addr = cnt_reg + CW'(1);
            ram_en   = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Controller state, read/err status and the held copy of rd.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      dump_valid_reg <= 1'b0;
      rvalid_reg     <= 1'b0;
      rd_oor_reg     <= 1'b0;
      err_reg        <= 1'b0;
      rd_hold_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      dump_valid_reg <= dump_valid_next;
      rvalid_reg     <= (state_reg == ST_IDLE) && re;
      rd_oor_reg     <= !in_range;
      err_reg        <= (we || re) && ((state_reg != ST_IDLE) || !in_range);
      rd_hold_reg    <= rd;
    end
  end

  // rd shows the fresh RAM word (or zero for a rejected address) only in
  // the rvalid cycle; otherwise it replays the last value it showed, so
  // CLEAR/DUMP traffic on the RAM output never leaks onto rd.
  assign rd         = rvalid_reg ? (rd_oor_reg ? '0 : ram_q) : rd_hold_reg;
  assign rvalid     = rvalid_reg;
  assign err        = err_reg;
  assign dump_valid = dump_valid_reg;
  assign dump_data  = dump_valid_reg ? ram_q : '0;
  assign dump_last  = dump_valid_reg && (cnt_reg == LAST_ADDR);
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dmem_bank.sv
// Randomised scoreboard bench for dmem_bank (DATA_W=32, DEPTH=16).
module tb_dmem_bank;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          we, re, clr_start, dump_start, dump_ready;
  logic [3:0]    be;
  logic [AW-1:0] address;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd, dump_data;
  logic          rvalid, err, dump_valid, dump_last, busy;

  dmem_bank #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .be         (be),
    .re         (re),
    .address    (address),
    .wd         (wd),
    .rd         (rd),
    .rvalid     (rvalid),
    .err        (err),
    .clr_start  (clr_start),
    .dump_start (dump_start),
    .dump_data  (dump_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_last  (dump_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int at; } rd_exp_t;
  typedef struct { logic [31:0] data; logic last; } dump_exp_t;
  rd_exp_t   rd_q[$];
  dump_exp_t dump_q[$];

  logic [31:0] model [DEPTH];
  int          err_exp = 0;
  int          err_seen = 0;
  int          dump_xfers = 0;
  logic [31:0] last_rd = '0;
  logic        stalled = 1'b0;
  logic [31:0] st_data;
  logic        st_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read or a dump word.
  always @(negedge clk) begin
    if (reset) begin
      last_rd = '0;
      stalled = 1'b0;
    end else begin
      if (rvalid) begin
        if (rd_q.size() == 0) begin
          check("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rd_data", rd, e.data);
          check("rd_latency", cyc, e.at);
          $display("[TB] read  cyc=%0d rd=%h exp=%h", cyc, rd, e.data);
        end
        last_rd = rd;
      end else begin
        check("rd_hold", rd, last_rd);
      end
      if (err) err_seen++;
      if (stalled) begin
        check("dump_hold_valid", dump_valid, 1);
        check("dump_hold_data", dump_data, st_data);
        check("dump_hold_last", dump_last, st_last);
      end
      stalled = dump_valid && !dump_ready;
      st_data = dump_data;
      st_last = dump_last;
      if (dump_valid && dump_ready) begin
        if (dump_q.size() == 0) begin
          check("dump_unexpected", 32'd1, 32'd0);
        end else begin
          dump_exp_t d;
          d = dump_q.pop_front();
          check("dump_data", dump_data, d.data);
          check("dump_last", dump_last, d.last);
          $display("[TB] dump  cyc=%0d data=%h last=%0b", cyc, dump_data, dump_last);
        end
        dump_xfers++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One IDLE access; the reference model is updated read-first.
  task automatic access(input logic w, input logic [3:0] b, input logic r,
                        input logic [AW-1:0] a, input logic [31:0] d);
    int ai;
    ai = int'(a);
    we = w; be = b; re = r; address = a; wd = d;
    if (ai < DEPTH) begin
      if (r) rd_q.push_back('{model[ai], cyc + 1});
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) model[ai][i*8 +: 8] = d[i*8 +: 8];
        end
      end
    end else begin
      if (w || r) err_exp++;
      if (r) rd_q.push_back('{32'h0, cyc + 1});
    end
    tick();
    we = 1'b0; re = 1'b0; be = '0;
  endtask

  task automatic do_clear(input logic with_re);
    int n;
    dump_ready = 1'b1;
    clr_start = 1'b1; dump_start = with_re;
    tick();
    clr_start = 1'b0; dump_start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (with_re && n == 2) begin
        re = 1'b1; address = 8'd3; err_exp++;
      end
      tick();
      re = 1'b0;
      n++;
    end
    check("clear_cycles", n, DEPTH);
    check("clear_no_dump", dump_valid, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic push_dump();
    for (int i = 0; i < DEPTH; i++) dump_q.push_back('{model[i], i == DEPTH - 1});
  endtask

  // mode 0: ready 1,0,1,0...; mode 1: random ready; mode 2: ready held high.
  task automatic run_dump(input int mode);
    int n;
    push_dump();
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("dump_busy", busy, 1);
    check("dump_valid_early", dump_valid, 0);
    tick();
    check("dump_first_valid", dump_valid, 1);
    check("dump_first_data", dump_data, model[0]);
    n = 0;
    while (busy && n < 200) begin
      if (mode == 0)      dump_ready = (n % 2 == 0);
      else if (mode == 1) dump_ready = 1'($urandom);
      else                dump_ready = 1'b1;
      tick();
      n++;
    end
    if (n >= 200) check("dump_timeout", 32'd1, 32'd0);
    if (mode == 0) check("dump_cycles_toggle", n, 2 * DEPTH - 1);
    if (mode == 2) check("dump_cycles_stream", n, DEPTH);
    check("dump_remaining", dump_q.size(), 0);
    check("dump_valid_after", dump_valid, 0);
    dump_ready = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd"}, rd, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_dump_data"}, dump_data, 0);
    check({tag, "_dump_valid"}, dump_valid, 0);
    check({tag, "_dump_last"}, dump_last, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    reset = 1'b1; we = 1'b0; re = 1'b0; be = '0; address = '0; wd = '0;
    clr_start = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_outputs_zero("reset");

    do_clear(1'b0);

    // Byte-lane write then read.
    access(1'b1, 4'b0101, 1'b0, 8'd5, 32'hDEADBEEF);
    access(1'b0, 4'b0000, 1'b1, 8'd5, 32'h0);

    // Read-first collision.
    access(1'b1, 4'b1111, 1'b0, 8'd3, 32'h22222222);
    access(1'b1, 4'b1111, 1'b1, 8'd3, 32'h11111111);
    access(1'b0, 4'b0000, 1'b1, 8'd3, 32'h0);

    // Out-of-range read and write; address 20 must not alias onto word 4.
    access(1'b0, 4'b0000, 1'b1, 8'd16, 32'h0);
    access(1'b1, 4'b1111, 1'b0, 8'd20, 32'hCAFEF00D);
    access(1'b0, 4'b0000, 1'b1, 8'd4, 32'h0);
    access(1'b0, 4'b0000, 1'b1, 8'd255, 32'h0);

    // Random IDLE traffic, including out-of-range addresses.
    for (int k = 0; k < 200; k++) begin
      access(1'($urandom), 4'($urandom), 1'($urandom),
             8'($urandom_range(0, 23)), $urandom);
    end

    // Fill mem[i] = i and dump with toggling ready.
    for (int i = 0; i < DEPTH; i++) access(1'b1, 4'b1111, 1'b0, 8'(i), 32'(i));
    run_dump(0);

    // Random data, random backpressure, then a full-rate dump.
    for (int i = 0; i < DEPTH; i++) access(1'b1, 4'b1111, 1'b0, 8'(i), $urandom);
    run_dump(1);
    run_dump(2);

    // Simultaneous clear and dump request with a read while busy.
    do_clear(1'b1);
    for (int i = 0; i < DEPTH; i++) access(1'b0, 4'b0000, 1'b1, 8'(i), 32'h0);

    // Reset in the middle of a dump, presenting word 7.
    for (int i = 0; i < DEPTH; i++) access(1'b1, 4'b1111, 1'b0, 8'(i), 32'h100 + 32'(i));
    base = dump_xfers;
    push_dump();
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    n = 0;
    while (dump_xfers < base + 7 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("mid_dump_timeout", 32'd1, 32'd0);
    check("mid_dump_word7", dump_data, model[7]);
    reset = 1'b1;
    dump_q.delete();
    #1;
    check_outputs_zero("mid_reset");
    tick();
    reset = 1'b0;
    dump_ready = 1'b0;
    tick();
    run_dump(2);

    tick(); tick();
    check("err_count", err_seen, err_exp);
    check("rd_queue_empty", rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
